// File: rtl/ls_unit_pkg.sv
// Shared types and defaults for the load/store functional unit.
package ls_unit_pkg;

   // Functional-unit opcodes issued by the reservation stations; only LDUR/STUR are served here.
   typedef enum logic [2:0] {
      FU_OP_ADD  = 3'd0,
      FU_OP_SUB  = 3'd1,
      FU_OP_AND  = 3'd2,
      FU_OP_ORR  = 3'd3,
      FU_OP_LDUR = 3'd4,
      FU_OP_STUR = 3'd5,
      FU_OP_CBZ  = 3'd6,
      FU_OP_B    = 3'd7
   } fu_op_t;

   // Load/store unit sequencing states.
   typedef enum logic [1:0] {
      LS_IDLE = 2'd0,
      LS_BUSY = 2'd1,
      LS_RESP = 2'd2
   } ls_state_t;

   localparam int LS_MEM_WORDS   = 256;
   localparam int LS_MEM_LATENCY = 2;

endpackage

// File: rtl/ls_dmem.sv
// Private data memory of the load/store unit: synchronous single-port RAM,
// write-first. Kept separate so it can be replaced by a cache interface.
module ls_dmem #(
   parameter int WIDTH = 64,
   parameter int WORDS = 256,
   parameter int IDX_W = 8
) (
   input  logic             in_clk,
   input  logic             in_we,
   input  logic [IDX_W-1:0] in_idx,
   input  logic [WIDTH-1:0] in_wdata,
   output logic [WIDTH-1:0] out_rdata
);

   logic [WIDTH-1:0] mem_r [WORDS];

   // Write the addressed word; read data follows the written value on the same edge.
   always_ff @(posedge in_clk) begin
      if (in_we) begin
         mem_r[in_idx] <= in_wdata;
         out_rdata     <= in_wdata;
      end else begin
         out_rdata     <= mem_r[in_idx];
      end
   end

endmodule

// File: rtl/ls_unit.sv
// Load/store functional unit: accepts one LDUR/STUR per handshake, accesses the
// private data memory over MEM_LATENCY cycles and reports a one-cycle completion.
module ls_unit
   import ls_unit_pkg::*;
#(
   parameter int GPR_SIZE     = 64,
   parameter int ROB_IDX_SIZE = 4,
   parameter int MEM_WORDS    = LS_MEM_WORDS,
   parameter int MEM_LATENCY  = LS_MEM_LATENCY
) (
   input  logic                    in_clk,
   input  logic                    in_rst,
   input  logic                    in_rs_ls_start,
   input  fu_op_t                  in_rs_ls_fu_op,
   input  logic [GPR_SIZE-1:0]     in_rs_ls_val_a,
   input  logic [GPR_SIZE-1:0]     in_rs_ls_val_b,
   input  logic [GPR_SIZE-1:0]     in_rs_ls_store_data,
   input  logic [ROB_IDX_SIZE-1:0] in_rs_ls_dst_rob_index,
   input  logic                    in_rob_is_mispred,
   output logic                    out_rs_ls_ready,
   output logic                    out_rob_done,
   output logic [ROB_IDX_SIZE-1:0] out_rob_dst_rob_index,
   output logic [GPR_SIZE-1:0]     out_rob_value,
   output logic                    out_rob_is_store
);

   localparam int IDX_W = $clog2(MEM_WORDS);
   localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);

   ls_state_t               state_r;
   ls_state_t               next_state_s;
   logic [CNT_W-1:0]        cnt_r;
   fu_op_t                  op_r;
   logic [ROB_IDX_SIZE-1:0] tag_r;
   logic [IDX_W-1:0]        widx_r;
   logic [GPR_SIZE-1:0]     sdata_r;
   logic                    accept_s;
   logic                    last_s;
   logic                    we_s;
   logic [GPR_SIZE-1:0]     rdata_s;
   logic [GPR_SIZE-1:0]     value_live_s;
   logic [GPR_SIZE-1:0]     value_hold_r;
   logic [ROB_IDX_SIZE-1:0] idx_out_r;
   logic                    is_store_out_r;

   // Next-state decode: accept, final access edge, store write enable and flush handling.
   always_comb begin
      next_state_s = state_r;
      accept_s     = 1'b0;
      last_s       = 1'b0;
      we_s         = 1'b0;
      case (state_r)
         LS_IDLE: begin
            if (in_rs_ls_start && !in_rob_is_mispred) begin
               accept_s     = 1'b1;
               next_state_s = LS_BUSY;
            end else begin
               next_state_s = LS_IDLE;
            end
         end
         LS_BUSY: begin
            if (in_rob_is_mispred) begin
               next_state_s = LS_IDLE;
            end else if (cnt_r == {CNT_W{1'b0}}) begin
               last_s       = 1'b1;
               we_s         = (op_r == FU_OP_STUR);
               next_state_s = LS_RESP;
            end else begin
               next_state_s = LS_BUSY;
            end
         end
         LS_RESP: begin
            next_state_s = LS_IDLE;
         end
         default: begin
            next_state_s = LS_IDLE;
         end
      endcase
   end

   // State register, latency counter and capture of the accepted operation.
   always_ff @(posedge in_clk or negedge in_rst) begin
      if (!in_rst) begin
         state_r <= LS_IDLE;
         cnt_r   <= {CNT_W{1'b0}};
         op_r    <= FU_OP_ADD;
         tag_r   <= {ROB_IDX_SIZE{1'b0}};
         widx_r  <= {IDX_W{1'b0}};
         sdata_r <= {GPR_SIZE{1'b0}};
      end else begin
         state_r <= next_state_s;
         if (accept_s) begin
            cnt_r   <= CNT_LOAD;
            op_r    <= in_rs_ls_fu_op;
            tag_r   <= in_rs_ls_dst_rob_index;
            // Word index of (base + offset): byte bits dropped, upper bits wrap.
            widx_r  <= IDX_W'((in_rs_ls_val_a + in_rs_ls_val_b) >> 3);
            sdata_r <= in_rs_ls_store_data;
         end else if ((state_r == LS_BUSY) && (cnt_r != {CNT_W{1'b0}})) begin
            cnt_r <= cnt_r - 1'b1;
         end
      end
   end

   // Completion tag/kind registered on the final access edge, held until the next completion.
   always_ff @(posedge in_clk or negedge in_rst) begin
      if (!in_rst) begin
         idx_out_r      <= {ROB_IDX_SIZE{1'b0}};
         is_store_out_r <= 1'b0;
         value_hold_r   <= {GPR_SIZE{1'b0}};
      end else begin
         if (last_s) begin
            idx_out_r      <= tag_r;
            is_store_out_r <= (op_r == FU_OP_STUR);
         end
         if (state_r == LS_RESP) begin
            value_hold_r <= value_live_s;
         end
      end
   end

   ls_dmem #(
      .WIDTH (GPR_SIZE),
      .WORDS (MEM_WORDS),
      .IDX_W (IDX_W)
   ) u_dmem (
      .in_clk    (in_clk),
      .in_we     (we_s),
      .in_idx    (widx_r),
      .in_wdata  (sdata_r),
      .out_rdata (rdata_s)
   );

   // Only a load returns memory data; stores and unsupported ops report zero.
   assign value_live_s          = (op_r == FU_OP_LDUR) ? rdata_s : {GPR_SIZE{1'b0}};
   assign out_rob_value         = (state_r == LS_RESP) ? value_live_s : value_hold_r;
   assign out_rob_dst_rob_index = idx_out_r;
   assign out_rob_is_store      = is_store_out_r;
   assign out_rs_ls_ready       = (state_r == LS_IDLE);
   assign out_rob_done          = (state_r == LS_RESP) && !in_rob_is_mispred;

endmodule
